// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard controller
// Purpose: FSM state and forwarding-select enums plus result-source encodings.
// Ports: none (package).
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    TIMEOUT = 2'd2
  } mc_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [1:0] RESULT_PC4  = 2'b10;

endpackage

// File: rtl/mc_stall_fsm.sv
// rtl/mc_stall_fsm.sv - multi-cycle op tracker with watchdog
// Purpose: tracks a multi-cycle op in E from start to done, aborting it after
//          MC_MAX_CYCLES busy cycles without a done.
// Ports: clk, rst_n (sync active-low); mc_start_i, mc_done_i from the E unit;
//        state_o current state; mc_stall_o stall request; mc_abort_o abort pulse.
module mc_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MC_MAX_CYCLES = 34
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      mc_start_i,
  input  logic      mc_done_i,
  output mc_state_t state_o,
  output logic      mc_stall_o,
  output logic      mc_abort_o
);

  localparam int CW = (MC_MAX_CYCLES > 2) ? $clog2(MC_MAX_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MC_MAX_CYCLES - 1);

  mc_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // start and done together is a single-cycle op: nothing to wait for
        if (mc_start_i && !mc_done_i) state_d = BUSY;
      end
      BUSY: begin
        if (mc_done_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = TIMEOUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TIMEOUT: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The stall covers the start cycle itself, and drops in the done cycle so
  // the op leaves E on that edge.
  assign mc_stall_o = ((state_q == BUSY) && !mc_done_i) ||
                      ((state_q == IDLE) && mc_start_i && !mc_done_i);
  assign mc_abort_o = (state_q == TIMEOUT);
  assign state_o    = state_q;

endmodule

// File: rtl/hazard_ctrl_mc.sv
// rtl/hazard_ctrl_mc.sv - pipeline hazard unit with multi-cycle op support
// Purpose: operand forwarding, load-use stall, branch flush and multi-cycle
//          stall/abort control; optional perf counters under HAZARD_PERF_CNT_EN.
// Ports: clk, rst_n; stage register addresses/enables/result selects and data;
//        PCSrcE, McStartE, McDoneE; outputs SrcAE/SrcBE, stall/flush/McAbort,
//        StallCnt/FlushCnt/TimeoutCnt (tied 0 without HAZARD_PERF_CNT_EN).
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_AW        = 5,
  parameter int MC_MAX_CYCLES = 34,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_AW-1:0]     Rs1D,
  input  logic [REG_AW-1:0]     Rs2D,
  input  logic [REG_AW-1:0]     Rs1E,
  input  logic [REG_AW-1:0]     Rs2E,
  input  logic [REG_AW-1:0]     RdE,
  input  logic [REG_AW-1:0]     RdM,
  input  logic [REG_AW-1:0]     RdW,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic [1:0]            ResultSrcE,
  input  logic [1:0]            ResultSrcM,
  input  logic [DATA_WIDTH-1:0] RD1E,
  input  logic [DATA_WIDTH-1:0] RD2E,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  input  logic [DATA_WIDTH-1:0] ResultW,
  input  logic                  PCSrcE,
  input  logic                  McStartE,
  input  logic                  McDoneE,
  output logic [DATA_WIDTH-1:0] SrcAE,
  output logic [DATA_WIDTH-1:0] SrcBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  McAbort,
  output logic [CNT_WIDTH-1:0]  StallCnt,
  output logic [CNT_WIDTH-1:0]  FlushCnt,
  output logic [CNT_WIDTH-1:0]  TimeoutCnt
);

  mc_state_t             mc_state;
  logic                  mc_stall;
  logic                  mc_abort;
  logic                  lw_stall;
  logic [DATA_WIDTH-1:0] m_val;
  fwd_sel_t              sel_a, sel_b;

  mc_stall_fsm #(
    .MC_MAX_CYCLES(MC_MAX_CYCLES)
  ) u_mc_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .mc_start_i(McStartE),
    .mc_done_i (McDoneE),
    .state_o   (mc_state),
    .mc_stall_o(mc_stall),
    .mc_abort_o(mc_abort)
  );

  // x0 is never forwarded; M is younger than W so it wins.
  function automatic fwd_sel_t fwd_sel(input logic [REG_AW-1:0] rs);
    if (rs != '0 && RegWriteM && rs == RdM) return FWD_MEM;
    if (rs != '0 && RegWriteW && rs == RdW) return FWD_WB;
    return FWD_RF;
  endfunction

  assign m_val = (ResultSrcM == RESULT_PC4) ? PCPlus4M : ALUResultM;

  always_comb begin
    sel_a = fwd_sel(Rs1E);
    sel_b = fwd_sel(Rs2E);
    case (sel_a)
      FWD_MEM: SrcAE = m_val;
      FWD_WB:  SrcAE = ResultW;
      default: SrcAE = RD1E;
    endcase
    case (sel_b)
      FWD_MEM: SrcBE = m_val;
      FWD_WB:  SrcBE = ResultW;
      default: SrcBE = RD2E;
    endcase
  end

  assign lw_stall = (ResultSrcE == RESULT_LOAD) && RegWriteE && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    McAbort = 1'b0;
    if (mc_abort) begin
      McAbort = 1'b1;
      FlushE  = 1'b1;
      FlushD  = 1'b1;
    end else if (mc_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (mc_state == IDLE) begin
      // A taken branch squashes the dependent instruction, so no stall needed.
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall && !McStartE) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q, tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      if (StallF && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (FlushE && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      // TIMEOUT lasts exactly one cycle, so each abort cycle is one entry
      if (mc_abort && tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign StallCnt   = stall_cnt_q;
  assign FlushCnt   = flush_cnt_q;
  assign TimeoutCnt = tmo_cnt_q;
`else
  assign StallCnt   = '0;
  assign FlushCnt   = '0;
  assign TimeoutCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb/tb_hazard_ctrl_mc.sv - self-checking bench for hazard_ctrl_mc
module tb_hazard_ctrl_mc;
  import hazard_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteE, RegWriteM, RegWriteW;
  logic [1:0]    ResultSrcE, ResultSrcM;
  logic [DW-1:0] RD1E, RD2E, ALUResultM, PCPlus4M, ResultW;
  logic          PCSrcE, McStartE, McDoneE;

  // ctl bit order: {StallF, StallD, StallE, FlushD, FlushE, FlushM, McAbort}
  logic [6:0]    ctl  [2];
  logic [DW-1:0] srca [2];
  logic [DW-1:0] srcb [2];
  logic [CW-1:0] sc   [2];
  logic [CW-1:0] fc   [2];
  logic [CW-1:0] tc   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic          sf, sd, se, fd, fe, fm, ab;
    logic [DW-1:0] sa, sb;
    logic [CW-1:0] s_cnt, f_cnt, t_cnt;
    hazard_ctrl_mc #(
      .DATA_WIDTH(DW), .REG_AW(AW), .MC_MAX_CYCLES(g == 0 ? 34 : 4), .CNT_WIDTH(CW)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM),
      .RD1E(RD1E), .RD2E(RD2E), .ALUResultM(ALUResultM), .PCPlus4M(PCPlus4M),
      .ResultW(ResultW), .PCSrcE(PCSrcE), .McStartE(McStartE), .McDoneE(McDoneE),
      .SrcAE(sa), .SrcBE(sb),
      .StallF(sf), .StallD(sd), .StallE(se), .FlushD(fd), .FlushE(fe), .FlushM(fm),
      .McAbort(ab), .StallCnt(s_cnt), .FlushCnt(f_cnt), .TimeoutCnt(t_cnt)
    );
    assign ctl[g]  = {sf, sd, se, fd, fe, fm, ab};
    assign srca[g] = sa;
    assign srcb[g] = sb;
    assign sc[g]   = s_cnt;
    assign fc[g]   = f_cnt;
    assign tc[g]   = t_cnt;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: an op is "pending" from its start edge until done or
  // until it has spent max_c cycles waiting; a watchdog expiry owes one abort.
  int         max_c [2] = '{34, 4};
  bit         pend  [2];
  int         age   [2];
  bit         abt   [2];
  longint     scnt  [2];
  longint     fcnt  [2];
  longint     tcnt  [2];
  logic [6:0] ectl  [2];

  function automatic longint pc(input longint v);
`ifdef HAZARD_PERF_CNT_EN
    return v;
`else
    return (v != 0) ? 64'd0 : 64'd0;
`endif
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] rs, input logic [DW-1:0] rf);
    logic [DW-1:0] mv;
    mv = (ResultSrcM == 2'b10) ? PCPlus4M : ALUResultM;
    if (rs != 0 && RegWriteM && rs == RdM) return mv;
    if (rs != 0 && RegWriteW && rs == RdW) return ResultW;
    return rf;
  endfunction

  task automatic settle();
    bit lw;
    @(negedge clk);
    lw = (ResultSrcE == 2'b01) && RegWriteE && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    for (int i = 0; i < 2; i++) begin
      ectl[i] = 7'b0;
      if (abt[i])                                          ectl[i] = 7'b0001101;
      else if (pend[i] ? !McDoneE : (McStartE && !McDoneE)) ectl[i] = 7'b1110010;
      else if (!pend[i] && PCSrcE)                         ectl[i] = 7'b0001100;
      else if (!pend[i] && lw && !McStartE)                ectl[i] = 7'b1100100;
      check($sformatf("ctl%0d", i), ctl[i], ectl[i]);
      check($sformatf("srca%0d", i), srca[i], fwd(Rs1E, RD1E));
      check($sformatf("srcb%0d", i), srcb[i], fwd(Rs2E, RD2E));
      check($sformatf("stallcnt%0d", i), sc[i], pc(scnt[i]));
      check($sformatf("flushcnt%0d", i), fc[i], pc(fcnt[i]));
      check($sformatf("tmocnt%0d", i), tc[i], pc(tcnt[i]));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        pend[i] = 0; age[i] = 0; abt[i] = 0;
        scnt[i] = 0; fcnt[i] = 0; tcnt[i] = 0;
      end else begin
        if (ectl[i][6]) scnt[i]++;
        if (ectl[i][2]) fcnt[i]++;
        if (abt[i])     tcnt[i]++;
        if (abt[i]) abt[i] = 0;
        else if (pend[i]) begin
          if (McDoneE) pend[i] = 0;
          else if (age[i] == max_c[i] - 1) begin pend[i] = 0; abt[i] = 1; end
          else age[i]++;
        end else if (McStartE && !McDoneE) begin
          pend[i] = 1; age[i] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic clear_in();
    rst_n = 1'b1;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, PCSrcE, McStartE, McDoneE} = '0;
    ResultSrcE = 2'b00; ResultSrcM = 2'b00;
    {RD1E, RD2E, ALUResultM, PCPlus4M, ResultW} = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    settle(); advance();
    rst_n = 1'b1;
  endtask

  int st0, st1, ab1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; age[i] = 0; abt[i] = 0; scnt[i] = 0; fcnt[i] = 0; tcnt[i] = 0;
    end
    clear_in();
    @(posedge clk); #1;
    do_reset();
    settle();
    check("reset_ctl", ctl[0], 7'b0);
    check("reset_stallcnt", sc[0], 64'd0);
    advance();

    // back-to-back ALU forwarding, M priority, then W only
    RdM = 5; RegWriteM = 1; Rs1E = 5; ALUResultM = 32'h1234; RD1E = 32'hdead;
    settle(); check("fwd_mem", srca[0], 32'h1234); advance();
    RdW = 5; RegWriteW = 1; ResultW = 32'h5555;
    settle(); check("fwd_mem_prio", srca[0], 32'h1234); advance();
    RegWriteM = 0;
    settle(); check("fwd_wb", srca[0], 32'h5555); advance();

    // x0 never forwards nor stalls
    clear_in();
    RdM = 0; RegWriteM = 1; Rs1E = 0; RD1E = 0; ALUResultM = 32'hffff;
    settle(); check("x0_fwd", srca[0], 32'h0); advance();
    ResultSrcE = 2'b01; RegWriteE = 1; RdE = 0; Rs1D = 0;
    settle(); check("x0_load", ctl[0], 7'b0); advance();

    // load-use, then load-use together with a taken branch
    clear_in();
    ResultSrcE = 2'b01; RegWriteE = 1; RdE = 7; Rs2D = 7;
    settle(); check("lw_stall", ctl[0], 7'b1100100); advance();
    PCSrcE = 1;
    settle(); check("lw_branch", ctl[0], 7'b0001100); advance();
    clear_in();
    settle(); check("lw_clear", ctl[0], 7'b0); advance();

    // JAL result forwarded from PC+4
    ResultSrcM = 2'b10; RdM = 1; RegWriteM = 1; Rs1E = 1; PCPlus4M = 32'h104; ALUResultM = 32'h999;
    settle(); check("jal_fwd", srca[0], 32'h104); advance();

    // multi-cycle op done five cycles after its start
    clear_in(); do_reset();
    st0 = 0;
    for (int c = 0; c < 6; c++) begin
      McStartE = (c == 0); McDoneE = (c == 5);
      settle();
      if (ctl[0][4]) st0++;
      if (c == 5) check("mc_done_release", ctl[0], 7'b0);
      advance();
    end
    clear_in();
    settle();
    check("mc_stall_cycles", st0, 5);
    check("mc_stallcnt", sc[0], pc(5));
    advance();

    // watchdog on the MC_MAX_CYCLES=4 instance, done never arrives
    clear_in(); do_reset();
    st1 = 0; ab1 = 0;
    for (int c = 0; c < 8; c++) begin
      McStartE = (c == 0);
      settle();
      if (ctl[1][4]) st1++;
      if (ctl[1][0]) ab1++;
      if (c == 5) check("wd_abort", ctl[1], 7'b0001101);
      advance();
    end
    check("wd_stall_cycles", st1, 5);
    check("wd_abort_cycles", ab1, 1);
    check("wd_tmocnt", tc[1], pc(1));
    // instance 0 is still busy: reset abandons the op silently
    check("busy_before_reset", ctl[0][4], 1'b1);
    do_reset();
    settle();
    check("rst_mid_abort", ctl[0][0], 1'b0);
    check("rst_mid_stall", ctl[0][4], 1'b0);
    advance();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      Rs1D = AW'($urandom_range(0, 3)); Rs2D = AW'($urandom_range(0, 3));
      Rs1E = AW'($urandom_range(0, 3)); Rs2E = AW'($urandom_range(0, 3));
      RdE = AW'($urandom_range(0, 3)); RdM = AW'($urandom_range(0, 3));
      RdW = AW'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      ResultSrcE = 2'($urandom); ResultSrcM = 2'($urandom);
      RD1E = $urandom; RD2E = $urandom; ALUResultM = $urandom;
      PCPlus4M = $urandom; ResultW = $urandom;
      PCSrcE = ($urandom_range(0, 5) == 0);
      McStartE = ($urandom_range(0, 9) == 0);
      McDoneE = ($urandom_range(0, 5) == 0);
      settle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
HAZARD_CTRL_MC -- requirements
Module: hazard_ctrl_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning datapath width.
REQ-002 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-003 SHALL have parameter MC_MAX_CYCLES, default 34, meaning the multi-cycle-op watchdog limit in cycles.
REQ-004 SHALL have parameter CNT_WIDTH, default 32, meaning perf-counter width.
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 SHALL have ports: clk  in  1  clock; rst_n  in  1  synchronous active-low reset.
REQ-007 SHALL have ports: Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  REG_AW  register addresses per stage.
REQ-008 SHALL have ports: RegWriteE, RegWriteM, RegWriteW  in  1  write enables; ResultSrcE, ResultSrcM  in  2  result-source select.
REQ-009 SHALL have ports: RD1E, RD2E, ALUResultM, PCPlus4M, ResultW  in  DATA_WIDTH  operand/result values.
REQ-010 SHALL have ports: PCSrcE  in  1  taken branch/jump; McStartE  in  1  multi-cycle op in E; McDoneE  in  1  multi-cycle result valid.
REQ-011 SHALL have ports: SrcAE, SrcBE  out  DATA_WIDTH  forwarded operands; StallF, StallD, StallE, FlushD, FlushE, FlushM, McAbort  out  1.
REQ-012 SHALL have ports: StallCnt, FlushCnt, TimeoutCnt  out  CNT_WIDTH  perf counters.

Function
REQ-013 SHALL forward per operand: from M if Rs==RdM, RegWriteM and Rs!=0; else from W if Rs==RdW, RegWriteW and Rs!=0; else the RF value; M has priority.
REQ-014 SHALL use PCPlus4M as the M forward value when ResultSrcM==RESULT_PC4, and ALUResultM otherwise.
REQ-015 SHALL raise lwStall when ResultSrcE==RESULT_LOAD, RegWriteE=1, RdE!=0 and RdE matches Rs1D or Rs2D; an rd of x0 never stalls.
REQ-016 SHALL drive StallF=StallD=FlushE=1 on lwStall when the FSM is IDLE and no McStartE is present.
REQ-017 SHALL run the FSM: IDLE->BUSY on McStartE&!McDoneE; BUSY->IDLE on McDoneE; BUSY->TIMEOUT when the busy counter reaches MC_MAX_CYCLES-1 without McDoneE; TIMEOUT->IDLE unconditionally.
REQ-018 SHALL treat McStartE&McDoneE in IDLE as a single-cycle op: no stall, stay IDLE.
REQ-019 SHALL assert StallF=StallD=StallE=FlushM=1 in BUSY, and in IDLE when McStartE&!McDoneE (combinational, same cycle).
REQ-020 SHALL release all stalls in the cycle McDoneE=1, so the op advances to M that cycle.
REQ-021 SHALL, in TIMEOUT, assert McAbort=FlushE=FlushD=1 for exactly one cycle with no stalls.
REQ-022 SHALL apply priority BUSY/TIMEOUT > PCSrcE > lwStall; PCSrcE and lwStall are ignored in BUSY.
REQ-023 SHALL drive FlushD=FlushE=1 on PCSrcE when not BUSY; PCSrcE with lwStall gives flush only, no stall.
REQ-024 SHALL hold the busy counter at 0 in IDLE, increment it each BUSY cycle, and clear it on exit.

Reset
REQ-025 SHALL, while rst_n=0 at a clk edge, set the FSM to IDLE and the busy counter and all perf counters to 0.
REQ-026 SHALL, in the cycle after reset, drive every stall/flush/McAbort output 0 unless inputs request it combinationally.
REQ-027 SHALL abandon an op when reset occurs mid-BUSY, with no McAbort pulse.

Configuration
REQ-028 SHALL, with HAZARD_PERF_CNT_EN defined, saturate at all-ones: StallCnt +1 per cycle with StallF=1; FlushCnt +1 per cycle with FlushE=1; TimeoutCnt +1 per TIMEOUT entry.
REQ-029 SHALL, without HAZARD_PERF_CNT_EN, keep all three counter ports, tie them to 0 and synthesise no counter flops.

Structure
REQ-030 SHALL take from package hazard_pkg: mc_state_t {IDLE,BUSY,TIMEOUT}, fwd_sel_t {FWD_RF,FWD_WB,FWD_MEM}, RESULT_LOAD=2'b01 and RESULT_PC4=2'b10.
REQ-031 SHALL place the FSM and busy counter in sub-module mc_stall_fsm, with forwarding and stall/flush logic in the top level.

Verification
REQ-032 SHALL test back-to-back ALU ops: RdM=5, RegWriteM=1, Rs1E=5, ALUResultM=0x1234 -> SrcAE=0x1234; RdM=5 and RdW=5 both writing -> M value wins.
REQ-033 SHALL test x0: RdM=0, Rs1E=0, RD1E=0 -> SrcAE=RD1E; load to x0 with Rs1D=0 -> no stall.
REQ-034 SHALL test load-use: ResultSrcE=01, RegWriteE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; with PCSrcE=1 same cycle -> FlushD=FlushE=1, StallF=0.
REQ-035 SHALL test JAL forwarding: ResultSrcM=10, RdM=1, Rs1E=1, PCPlus4M=0x104 -> SrcAE=0x104.
REQ-036 SHALL test a multi-cycle op: McStartE pulse, McDoneE after 5 cycles -> StallE=FlushM=1 for exactly 5 cycles, 0 in the done cycle; StallCnt=5 when enabled.
REQ-037 SHALL test the watchdog: MC_MAX_CYCLES=4, McDoneE held 0 -> 4 BUSY cycles, then one McAbort=FlushE=1 cycle, then IDLE; TimeoutCnt=1; rst_n=0 mid-BUSY -> IDLE next cycle, no McAbort.
